// File: rtl/openofdm_rx_cfg_sequencer_pkg.sv
// rtl/openofdm_rx_cfg_sequencer_pkg.sv - shared constants and types for the rx threshold update sequencer
package openofdm_rx_cfg_sequencer_pkg;

  // Decoder state in which the dot11 core is waiting for a power trigger (common params value).
  localparam logic [4:0] S_WAIT_POWER_TRIGGER = 5'd0;

  localparam int FORCED_CNT_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_IDLE = 3'd1,
    ST_APPLY     = 3'd2,
    ST_RESET     = 3'd3,
    ST_SETTLE    = 3'd4
  } seq_state_t;

  function automatic logic [FORCED_CNT_WIDTH-1:0] sat_inc(input logic [FORCED_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/openofdm_rx_cfg_req_slot.sv
// rtl/openofdm_rx_cfg_req_slot.sv - one coalescing pending-request slot
module openofdm_rx_cfg_req_slot
  import openofdm_rx_cfg_sequencer_pkg::*;
#(
  parameter int WIDTH = 11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             set,
  input  logic [WIDTH-1:0] set_value,
  input  logic             consume,
  output logic             valid,
  output logic [WIDTH-1:0] value
);

  // A new request outranks a consume in the same cycle so it is never lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      value <= '0;
    end else if (set) begin
      valid <= 1'b1;
      value <= set_value;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/openofdm_rx_cfg_sequencer.sv
// rtl/openofdm_rx_cfg_sequencer.sv - arbitrates threshold updates and applies them while the receiver is idle
module openofdm_rx_cfg_sequencer
  import openofdm_rx_cfg_sequencer_pkg::*;
#(
  parameter int RSSI_HALF_DB_WIDTH = 11,
  parameter int RST_LEN_WIDTH      = 4,
  parameter int SETTLE_WIDTH       = 8,
  parameter int TIMEOUT_WIDTH      = 16,
  parameter logic [RSSI_HALF_DB_WIDTH-1:0] TH_RESET = '0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          sw_req,
  input  logic [RSSI_HALF_DB_WIDTH-1:0] sw_th,
  input  logic                          agent_req,
  input  logic [RSSI_HALF_DB_WIDTH-2:0] agent_th,
  input  logic [4:0]                    rx_state,
  input  logic                          demod_is_ongoing,
  input  logic [RST_LEN_WIDTH-1:0]      rst_len,
  input  logic [SETTLE_WIDTH-1:0]       settle_len,
  input  logic [TIMEOUT_WIDTH-1:0]      idle_timeout,
  output logic [RSSI_HALF_DB_WIDTH-1:0] th_out,
  output logic                          th_update_stb,
  output logic                          rx_core_rst,
  output logic                          busy,
  output logic [FORCED_CNT_WIDTH-1:0]   forced_cnt
);

  seq_state_t                    state;
  logic [RSSI_HALF_DB_WIDTH-1:0] cand_th;
  logic [TIMEOUT_WIDTH-1:0]      wait_cnt;
  logic [TIMEOUT_WIDTH-1:0]      timeout_r;
  logic [RST_LEN_WIDTH-1:0]      rst_cnt;
  logic [SETTLE_WIDTH-1:0]       settle_cnt;

  logic                          sw_valid;
  logic                          ag_valid;
  logic [RSSI_HALF_DB_WIDTH-1:0] sw_value;
  logic [RSSI_HALF_DB_WIDTH-1:0] ag_value;
  logic                          sw_consume;
  logic                          ag_consume;
  logic                          rx_idle;
  logic                          timeout_hit;

  assign ag_consume  = (state == ST_IDLE) && ag_valid;
  assign sw_consume  = (state == ST_IDLE) && sw_valid && !ag_valid;
  assign rx_idle     = !demod_is_ongoing && (rx_state == S_WAIT_POWER_TRIGGER);
  assign timeout_hit = (timeout_r != '0) && (wait_cnt == timeout_r - 1'b1);

  openofdm_rx_cfg_req_slot #(.WIDTH(RSSI_HALF_DB_WIDTH)) u_sw_slot (
    .clock     (clock),
    .reset     (reset),
    .set       (sw_req),
    .set_value (sw_th),
    .consume   (sw_consume),
    .valid     (sw_valid),
    .value     (sw_value)
  );

  openofdm_rx_cfg_req_slot #(.WIDTH(RSSI_HALF_DB_WIDTH)) u_agent_slot (
    .clock     (clock),
    .reset     (reset),
    .set       (agent_req),
    .set_value ({1'b0, agent_th}),
    .consume   (ag_consume),
    .valid     (ag_valid),
    .value     (ag_value)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      th_out     <= TH_RESET;
      cand_th    <= '0;
      wait_cnt   <= '0;
      timeout_r  <= '0;
      rst_cnt    <= '0;
      settle_cnt <= '0;
      forced_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ag_valid) begin
            cand_th   <= ag_value;
            wait_cnt  <= '0;
            timeout_r <= idle_timeout;
            state     <= ST_WAIT_IDLE;
          end else if (sw_valid) begin
            cand_th   <= sw_value;
            wait_cnt  <= '0;
            timeout_r <= idle_timeout;
            state     <= ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          wait_cnt <= wait_cnt + 1'b1;
          // An idle receiver wins over a coincident timeout, so it is not counted as forced.
          if (rx_idle) begin
            th_out <= cand_th;
            state  <= ST_APPLY;
          end else if (timeout_hit) begin
            th_out     <= cand_th;
            forced_cnt <= sat_inc(forced_cnt);
            state      <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          // The APPLY cycle itself is the first reset cycle; RESET covers the remainder.
          if (rst_len <= RST_LEN_WIDTH'(1)) begin
            settle_cnt <= settle_len;
            state      <= (settle_len == '0) ? ST_IDLE : ST_SETTLE;
          end else begin
            rst_cnt <= rst_len - 1'b1;
            state   <= ST_RESET;
          end
        end
        ST_RESET: begin
          if (rst_cnt <= RST_LEN_WIDTH'(1)) begin
            settle_cnt <= settle_len;
            state      <= (settle_len == '0) ? ST_IDLE : ST_SETTLE;
          end else begin
            rst_cnt <= rst_cnt - 1'b1;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt <= SETTLE_WIDTH'(1)) begin
            state <= ST_IDLE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign th_update_stb = (state == ST_APPLY);
  assign rx_core_rst   = (state == ST_APPLY) || (state == ST_RESET);
  assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_openofdm_rx_cfg_sequencer.sv
// tb/tb_openofdm_rx_cfg_sequencer.sv - self-checking bench for the rx threshold update sequencer
module tb_openofdm_rx_cfg_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sw_req = 1'b0;
  logic [10:0] sw_th = '0;
  logic        agent_req = 1'b0;
  logic [9:0]  agent_th = '0;
  logic [4:0]  rx_state = 5'd0;
  logic        demod_is_ongoing = 1'b0;
  logic [3:0]  rst_len = 4'd3;
  logic [7:0]  settle_len = 8'd5;
  logic [15:0] idle_timeout = 16'd0;
  logic [10:0] th_out;
  logic        th_update_stb;
  logic        rx_core_rst;
  logic        busy;
  logic [7:0]  forced_cnt;

  openofdm_rx_cfg_sequencer dut (
    .clock            (clock),
    .reset            (reset),
    .sw_req           (sw_req),
    .sw_th            (sw_th),
    .agent_req        (agent_req),
    .agent_th         (agent_th),
    .rx_state         (rx_state),
    .demod_is_ongoing (demod_is_ongoing),
    .rst_len          (rst_len),
    .settle_len       (settle_len),
    .idle_timeout     (idle_timeout),
    .th_out           (th_out),
    .th_update_stb    (th_update_stb),
    .rx_core_rst      (rx_core_rst),
    .busy             (busy),
    .forced_cnt       (forced_cnt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at time %0t", name, got, exp, $time);
    end
  endtask

  // Deadline-based model: each update is a timeline of wait, reset window and settle window.
  int t = 0;
  int ph = 0;
  int wait_entry, apply_at, rst_end, settle_end, m_t_out;
  int m_th = 0, m_forced = 0, cand = 0, n;
  int m_sw_d = 0, m_ag_d = 0;
  bit m_sw_v = 0, m_ag_v = 0, idle_now;
  bit model_ok = 0;
  bit exp_stb = 0, exp_rst = 0, exp_busy = 0;

  always @(posedge clock) begin
    t++;
    if (reset) begin
      ph = 0; m_th = 0; m_forced = 0; m_sw_v = 0; m_ag_v = 0; model_ok = 1;
    end else begin
      case (ph)
        0: begin
          if (m_ag_v) begin
            cand = m_ag_d; m_ag_v = 0; ph = 1; wait_entry = t; m_t_out = int'(idle_timeout);
          end else if (m_sw_v) begin
            cand = m_sw_d; m_sw_v = 0; ph = 1; wait_entry = t; m_t_out = int'(idle_timeout);
          end
        end
        1: begin
          idle_now = (demod_is_ongoing == 1'b0) && (rx_state == 5'd0);
          n = t - wait_entry - 1;
          if (idle_now || (m_t_out != 0 && n == m_t_out - 1)) begin
            if (!idle_now && m_forced < 255) m_forced++;
            m_th = cand; apply_at = t; ph = 2; rst_end = t + 1000;
          end
        end
        2: begin
          if (t == apply_at + 1) rst_end = apply_at + ((rst_len == 0) ? 1 : int'(rst_len));
          if (t >= rst_end) begin
            if (settle_len == 0) ph = 0;
            else begin settle_end = t + int'(settle_len); ph = 3; end
          end
        end
        default: if (t >= settle_end) ph = 0;
      endcase
      if (sw_req) begin m_sw_v = 1; m_sw_d = int'(sw_th); end
      if (agent_req) begin m_ag_v = 1; m_ag_d = int'(agent_th); end
    end
    exp_stb  = (ph == 2) && (t == apply_at);
    exp_rst  = (ph == 2);
    exp_busy = (ph != 0);
  end

  int stb_count = 0;
  always @(negedge clock) begin
    if (th_update_stb === 1'b1) stb_count++;
    if (model_ok) begin
      check("th_out", 32'(th_out), 32'(m_th));
      check("th_update_stb", 32'(th_update_stb), 32'(exp_stb));
      check("rx_core_rst", 32'(rx_core_rst), 32'(exp_rst));
      check("busy", 32'(busy), 32'(exp_busy));
      check("forced_cnt", 32'(forced_cnt), 32'(m_forced));
    end
  end

  task automatic wait_cyc(input int k);
    repeat (k) @(negedge clock);
  endtask

  task automatic pulse_sw(input logic [10:0] v);
    sw_req = 1'b1; sw_th = v;
    @(negedge clock);
    sw_req = 1'b0;
  endtask

  task automatic pulse_agent(input logic [9:0] v);
    agent_req = 1'b1; agent_th = v;
    @(negedge clock);
    agent_req = 1'b0;
  endtask

  int base;

  initial begin
    wait_cyc(3);
    check("rst_th_out", 32'(th_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_core_rst", 32'(rx_core_rst), 32'd0);
    check("rst_stb", 32'(th_update_stb), 32'd0);
    check("rst_forced", 32'(forced_cnt), 32'd0);
    reset = 1'b0;
    wait_cyc(5);

    // Basic latency: stb at N+3, reset window 3 cycles, busy falls at N+11.
    rst_len = 4'd3; settle_len = 8'd5;
    pulse_sw(11'd400);
    wait_cyc(2);
    check("t1_stb", 32'(th_update_stb), 32'd1);
    check("t1_th", 32'(th_out), 32'd400);
    check("t1_rst_first", 32'(rx_core_rst), 32'd1);
    wait_cyc(2);
    check("t1_rst_last", 32'(rx_core_rst), 32'd1);
    wait_cyc(1);
    check("t1_rst_off", 32'(rx_core_rst), 32'd0);
    wait_cyc(4);
    check("t1_busy_hi", 32'(busy), 32'd1);
    wait_cyc(1);
    check("t1_busy_lo", 32'(busy), 32'd0);
    wait_cyc(3);

    // Agent outranks software; software served next.
    settle_len = 8'd0;
    base = stb_count;
    agent_req = 1'b1; agent_th = 10'd300; sw_req = 1'b1; sw_th = 11'd500;
    @(negedge clock);
    agent_req = 1'b0; sw_req = 1'b0;
    wait_cyc(2);
    check("t2_first_th", 32'(th_out), 32'd300);
    wait_cyc(5);
    check("t2_second_stb", 32'(th_update_stb), 32'd1);
    check("t2_second_th", 32'(th_out), 32'd500);
    wait_cyc(10);
    check("t2_stb_count", 32'(stb_count - base), 32'd2);

    // Waits forever while demodulating when timeout is 0.
    settle_len = 8'd5;
    demod_is_ongoing = 1'b1;
    pulse_sw(11'd123);
    wait_cyc(50);
    check("t3_busy_wait", 32'(busy), 32'd1);
    check("t3_th_held", 32'(th_out), 32'd500);
    demod_is_ongoing = 1'b0;
    wait_cyc(1);
    check("t3_stb", 32'(th_update_stb), 32'd1);
    check("t3_th", 32'(th_out), 32'd123);
    check("t3_forced", 32'(forced_cnt), 32'd0);
    wait_cyc(15);

    // Forced application after 20 cycles of waiting.
    rx_state = 5'd5; idle_timeout = 16'd20;
    pulse_sw(11'd222);
    wait_cyc(20);
    check("t4_no_stb_yet", 32'(th_update_stb), 32'd0);
    wait_cyc(1);
    check("t4_stb", 32'(th_update_stb), 32'd1);
    check("t4_th", 32'(th_out), 32'd222);
    check("t4_forced", 32'(forced_cnt), 32'd1);
    rx_state = 5'd0; idle_timeout = 16'd0;
    wait_cyc(15);

    // Coalescing during settle: only the latest value is applied.
    settle_len = 8'd20;
    pulse_sw(11'd50);
    wait_cyc(6);
    check("t5_in_settle", 32'(busy), 32'd1);
    base = stb_count;
    pulse_sw(11'd100);
    pulse_sw(11'd200);
    pulse_sw(11'd300);
    wait_cyc(60);
    check("t5_stb_count", 32'(stb_count - base), 32'd1);
    check("t5_th", 32'(th_out), 32'd300);

    // Reset mid-RESET discards the pending agent request.
    settle_len = 8'd5; rst_len = 4'd8;
    pulse_sw(11'd77);
    wait_cyc(3);
    pulse_agent(10'd99);
    check("t6_in_reset", 32'(rx_core_rst), 32'd1);
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    check("t6_core_rst", 32'(rx_core_rst), 32'd0);
    check("t6_th", 32'(th_out), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    base = stb_count;
    wait_cyc(40);
    check("t6_no_update", 32'(stb_count - base), 32'd0);
    check("t6_th_final", 32'(th_out), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
